// File: rtl/spi_flash_reader.sv
// Mode-0 single-bit SPI flash word reader: issues 0x03 + 24-bit address and
// returns the following four bytes as a little-endian 32-bit word.
module spi_flash_reader #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        SPI_sck_o,
    output logic        SPI_sck_t,
    output logic        SPI_ss_o,
    output logic        SPI_ss_t,
    output logic        SPI_io0_o,
    output logic        SPI_io0_t,
    input  logic        SPI_io1_i,
    output logic        SPI_io1_t
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        RESP,
        DESEL
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state;
    logic [7:0]  r_div;
    logic [5:0]  r_bit;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic        r_sck;
    logic        r_ss;
    logic        r_io0;
    logic        r_io0_t;
    logic        r_ready;
    logic        r_busy;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;

    logic        w_div_done;
    logic        w_accept;
    logic [31:0] w_tx_load;

    assign w_div_done = (r_div == DIV_LAST);
    assign w_accept   = req_valid && r_ready;
    assign w_tx_load  = {8'h03, req_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_sck        <= 1'b0;
            r_ss         <= 1'b1;
            r_io0        <= 1'b0;
            r_io0_t      <= 1'b1;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_div        <= r_div + 8'd1;
            case (r_state)
                IDLE: begin
                    r_div <= '0;
                    if (w_accept) begin
                        r_tx    <= w_tx_load;
                        r_rx    <= '0;
                        r_bit   <= '0;
                        r_ss    <= 1'b0;
                        r_io0   <= w_tx_load[31];
                        r_io0_t <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        r_sck <= ~r_sck;
                        if (!r_sck) begin
                            // Only the data phase (bits 32..63) is captured.
                            if (r_bit[5]) begin
                                r_rx <= {r_rx[30:0], SPI_io1_i};
                            end
                        end else begin
                            r_bit <= r_bit + 6'd1;
                            r_tx  <= {r_tx[30:0], 1'b0};
                            r_io0 <= r_tx[30];
                            if (r_bit == 6'd63) begin
                                r_state <= CS_HOLD;
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (w_div_done) begin
                        r_div        <= '0;
                        r_ss         <= 1'b1;
                        r_io0_t      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    r_div   <= '0;
                    r_state <= DESEL;
                end
                DESEL: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign SPI_sck_o  = r_sck;
    assign SPI_sck_t  = 1'b0;
    assign SPI_ss_o   = r_ss;
    assign SPI_ss_t   = 1'b0;
    assign SPI_io0_o  = r_io0;
    assign SPI_io0_t  = r_io0_t;
    assign SPI_io1_t  = 1'b1;

endmodule
